// File: rtl/xtop.sv
// Two's-complement calculator top: button-driven sequencer writing operands, sum and
// negated sum into a register file, with the sum shown as sign + hex magnitude.

module xtop_regf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic              disp_sign,
    output logic [11:0]       disp_low
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regf [0:DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regf[i] <= '0;
        end else if (we) begin
            regf[waddr] <= wdata;
        end
    end

    assign rd_a = regf[ra_a];
    assign rd_b = regf[ra_b];
    // Display tap on entry 2 (the sum): only sign and low 12 bits are ever shown.
    assign disp_sign = regf[2][DATA_W-1];
    assign disp_low  = regf[2][11:0];
endmodule

module xtop #(
    parameter int DATA_W      = 32,
    parameter int REGF_ADDR_W = 4,
    parameter int DISP_DIV_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Btn3,
    input  logic       Btn2,
    input  logic [7:0] Sw,
    output logic       trap,
    output logic [7:0] Disp,
    output logic [3:0] Disp_sel
);
    localparam logic [2:0] PC_IDLE = 3'd0;
    localparam logic [2:0] PC_LDA  = 3'd1;
    localparam logic [2:0] PC_LDB  = 3'd2;
    localparam logic [2:0] PC_ADD  = 3'd3;
    localparam logic [2:0] PC_NEG  = 3'd4;

    logic                   btn3_q, btn2_q;
    logic [7:0]             sw_q;
    logic [2:0]             pc;
    logic                   data_we;
    logic [REGF_ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0]      data_wdata;
    logic [REGF_ADDR_W-1:0] ra_a, ra_b;
    logic [DATA_W-1:0]      rd_a, rd_b;
    logic [DATA_W-1:0]      sw_ext;
    logic                   disp_sign;
    logic [11:0]            disp_low;

    assign sw_ext = {{(DATA_W-8){sw_q[7]}}, sw_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn3_q <= 1'b0;
            btn2_q <= 1'b0;
            sw_q   <= '0;
            pc     <= PC_IDLE;
            trap   <= 1'b0;
        end else begin
            btn3_q <= Btn3;
            btn2_q <= Btn2;
            sw_q   <= Sw;
            case (pc)
                PC_IDLE: begin
                    if (!trap) begin
                        if (btn3_q && btn2_q) trap <= 1'b1;
                        else if (btn3_q)      pc   <= PC_LDA;
                        else if (btn2_q)      pc   <= PC_LDB;
                    end
                end
                PC_LDA:  pc <= PC_IDLE;
                PC_LDB:  pc <= PC_ADD;
                PC_ADD:  pc <= PC_NEG;
                PC_NEG:  pc <= PC_IDLE;
                default: begin
                    trap <= 1'b1;
                    pc   <= PC_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        ra_a       = '0;
        ra_b       = '0;
        case (pc)
            PC_LDA: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(0);
                data_wdata = sw_ext;
            end
            PC_LDB: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(1);
                data_wdata = sw_ext;
            end
            PC_ADD: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(2);
                ra_a       = REGF_ADDR_W'(0);
                ra_b       = REGF_ADDR_W'(1);
                data_wdata = rd_a + rd_b;
            end
            PC_NEG: begin
                data_we    = 1'b1;
                data_addr  = REGF_ADDR_W'(3);
                ra_a       = REGF_ADDR_W'(2);
                data_wdata = ~rd_a + DATA_W'(1);
            end
            default: ;
        endcase
    end

    xtop_regf #(
        .DATA_W (DATA_W),
        .ADDR_W (REGF_ADDR_W)
    ) regf (
        .clk       (clk),
        .rst       (rst),
        .we        (data_we),
        .waddr     (data_addr),
        .wdata     (data_wdata),
        .ra_a      (ra_a),
        .ra_b      (ra_b),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .disp_sign (disp_sign),
        .disp_low  (disp_low)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [DISP_DIV_W-1:0] div_cnt;
    logic [1:0]            dig_idx;
    logic [11:0]           mag;
    logic [7:0]            seg_next;

    // |S| mod 2^12 equals the 12-bit negation of the low bits when S is negative.
    assign mag = disp_sign ? (~disp_low + 12'd1) : disp_low;

    always_comb begin
        seg_next = 8'hFF;
        case (dig_idx)
            2'd0: seg_next = {1'b1, hex7(mag[3:0])};
            2'd1: seg_next = {1'b1, hex7(mag[7:4])};
            2'd2: seg_next = {1'b1, hex7(mag[11:8])};
            default: seg_next = disp_sign ? 8'hBF : 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            dig_idx  <= 2'd0;
            Disp     <= 8'hFF;
            Disp_sel <= 4'hF;
        end else begin
            div_cnt <= div_cnt + DISP_DIV_W'(1);
            if (div_cnt == '1) begin
                dig_idx  <= dig_idx + 2'd1;
                Disp     <= seg_next;
                Disp_sel <= ~(4'b0001 << dig_idx);
            end
        end
    end
endmodule

// File: tb/tb_xtop.sv
// Directed vector bench for xtop: operand table plus hand-written latency, reset and
// trap sequences.

module tb_xtop;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Btn3 = 1'b0;
    logic       Btn2 = 1'b0;
    logic [7:0] Sw = 8'h00;
    logic       trap;
    logic [7:0] Disp;
    logic [3:0] Disp_sel;

    int tests = 0;
    int fails = 0;

    xtop #(
        .DATA_W      (32),
        .REGF_ADDR_W (4),
        .DISP_DIV_W  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Btn3     (Btn3),
        .Btn2     (Btn2),
        .Sw       (Sw),
        .trap     (trap),
        .Disp     (Disp),
        .Disp_sel (Disp_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] r0, r1, r2, r3;
        logic [7:0]  d0, d1, d2, d3;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input bit use_b, input logic [7:0] v);
        @(negedge clk);
        Sw = v;
        if (use_b) Btn2 = 1'b1; else Btn3 = 1'b1;
        @(negedge clk);
        Btn2 = 1'b0;
        Btn3 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic capture(output logic [7:0] s0, output logic [7:0] s1,
                           output logic [7:0] s2, output logic [7:0] s3);
        s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
        repeat (40) begin
            @(negedge clk);
            case (Disp_sel)
                4'hE: s0 = Disp;
                4'hD: s1 = Disp;
                4'hB: s2 = Disp;
                4'h7: s3 = Disp;
                default: ;
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s0, s1, s2, s3;
        bit found;

        //              a      b      r0            r1            r2            r3            d0     d1     d2     d3
        vecs[0] = '{8'hF1, 8'h01, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFF2, 32'h0000000E, 8'h86, 8'hC0, 8'hC0, 8'hBF};
        vecs[1] = '{8'h7F, 8'h7F, 32'h0000007F, 32'h0000007F, 32'h000000FE, 32'hFFFFFF02, 8'h86, 8'h8E, 8'hC0, 8'hFF};
        vecs[2] = '{8'h80, 8'h80, 32'hFFFFFF80, 32'hFFFFFF80, 32'hFFFFFF00, 32'h00000100, 8'hC0, 8'hC0, 8'hF9, 8'hBF};
        vecs[3] = '{8'h00, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 8'hC0, 8'hC0, 8'hC0, 8'hFF};
        vecs[4] = '{8'h5A, 8'hC3, 32'h0000005A, 32'hFFFFFFC3, 32'h0000001D, 32'hFFFFFFE3, 8'hA1, 8'hF9, 8'hC0, 8'hFF};
        vecs[5] = '{8'hA5, 8'h80, 32'hFFFFFFA5, 32'hFFFFFF80, 32'hFFFFFF25, 32'h000000DB, 8'h83, 8'hA1, 8'hC0, 8'hBF};

        // Reset state and first display refresh
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pc", 32'(dut.pc), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_disp", 32'(Disp), 32'hFF);
        chk("rst_sel", 32'(Disp_sel), 32'hF);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_regf%0d", i), dut.regf.regf[i], 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("disp_pre_wrap", 32'(Disp), 32'hFF);
        @(posedge clk);
        #1 chk("disp_first", 32'(Disp), 32'hC0);
        chk("sel_first", 32'(Disp_sel), 32'hE);

        // Btn3 held: latency of the A-load path
        @(negedge clk);
        Sw = 8'hF1;
        Btn3 = 1'b1;
        @(posedge clk); #1 chk("b3_pc_n", 32'(dut.pc), 32'd0);
        @(posedge clk); #1 chk("b3_pc_n1", 32'(dut.pc), 32'd1);
        @(posedge clk); #1 chk("b3_regf0", dut.regf.regf[0], 32'hFFFFFFF1);
        chk("b3_pc_n2", 32'(dut.pc), 32'd0);
        @(negedge clk);
        Btn3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("b3_regf1", dut.regf.regf[1], 32'd0);
        chk("b3_regf2", dut.regf.regf[2], 32'd0);
        chk("b3_regf3", dut.regf.regf[3], 32'd0);

        // Btn2 path: pc walks 2,3,4,0 with writes on each exit edge
        Sw = 8'h01;
        Btn2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 chk("b2_pc2", 32'(dut.pc), 32'd2);
        @(negedge clk); Btn2 = 1'b0;
        @(posedge clk); #1 chk("b2_pc3", 32'(dut.pc), 32'd3);
        chk("b2_regf1", dut.regf.regf[1], 32'h00000001);
        @(posedge clk); #1 chk("b2_pc4", 32'(dut.pc), 32'd4);
        chk("b2_regf2", dut.regf.regf[2], 32'hFFFFFFF2);
        @(posedge clk); #1 chk("b2_pc0", 32'(dut.pc), 32'd0);
        chk("b2_regf3", dut.regf.regf[3], 32'h0000000E);
        repeat (4) @(negedge clk);

        // Operand table
        for (int v = 0; v < 6; v++) begin
            pulse(1'b0, vecs[v].a);
            pulse(1'b1, vecs[v].b);
            chk($sformatf("v%0d_r0", v), dut.regf.regf[0], vecs[v].r0);
            chk($sformatf("v%0d_r1", v), dut.regf.regf[1], vecs[v].r1);
            chk($sformatf("v%0d_r2", v), dut.regf.regf[2], vecs[v].r2);
            chk($sformatf("v%0d_r3", v), dut.regf.regf[3], vecs[v].r3);
            capture(s0, s1, s2, s3);
            chk($sformatf("v%0d_dig0", v), 32'(s0), 32'(vecs[v].d0));
            chk($sformatf("v%0d_dig1", v), 32'(s1), 32'(vecs[v].d1));
            chk($sformatf("v%0d_dig2", v), 32'(s2), 32'(vecs[v].d2));
            chk($sformatf("v%0d_dig3", v), 32'(s3), 32'(vecs[v].d3));
        end
        for (int i = 4; i < 16; i++) chk($sformatf("regf%0d_untouched", i), dut.regf.regf[i], 32'd0);

        // Reset while pc=3 aborts the sequence
        @(negedge clk);
        Sw = 8'h11;
        Btn2 = 1'b1;
        @(negedge clk);
        Btn2 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (dut.pc == 3'd3) found = 1'b1;
        end
        chk("reach_pc3", 32'(found), 32'd1);
        rst = 1'b1;
        #1 chk("abort_pc", 32'(dut.pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_pc_after", 32'(dut.pc), 32'd0);
        chk("abort_regf2", dut.regf.regf[2], 32'd0);
        chk("abort_regf3", dut.regf.regf[3], 32'd0);

        // Both buttons in IDLE -> sticky trap, no further writes
        @(negedge clk);
        Sw = 8'h33;
        Btn3 = 1'b1;
        Btn2 = 1'b1;
        @(posedge clk); #1 chk("trap_n", 32'(trap), 32'd0);
        @(posedge clk); #1 chk("trap_n1", 32'(trap), 32'd1);
        @(negedge clk);
        Btn3 = 1'b0;
        Btn2 = 1'b0;
        pulse(1'b0, 8'h44);
        pulse(1'b1, 8'h55);
        chk("trap_regf0", dut.regf.regf[0], 32'd0);
        chk("trap_regf1", dut.regf.regf[1], 32'd0);
        chk("trap_sticky", 32'(trap), 32'd1);
        chk("trap_pc", 32'(dut.pc), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("trap_cleared", 32'(trap), 32'd0);
        pulse(1'b0, 8'h44);
        chk("post_trap_regf0", dut.regf.regf[0], 32'h00000044);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
